orsram_reader: RTL and testbench

Read-side controller for the output-result SRAM bank (`SRAM_NUM` single-port 128x16 macros sharing one chip enable). On a start command it streams a contiguous block of words, one full-bank-width word per address, out of the bank onto a valid/ready output stream. It hides the one-cycle macro read latency with a 2-entry skid FIFO. It sits between the orsram bank and the downstream result-drain / output DMA logic.

---
 rtl/orsram_reader_if.sv | 33 +++
 rtl/orsram_reader.sv | 130 +++++++++++++
 tb/tb_orsram_reader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/orsram_reader_if.sv
// Bundle of start/command, SRAM bank and output-stream signals for orsram_reader.
interface orsram_reader_if #(
  parameter int unsigned SRAM_NUM = 8,
  parameter int unsigned ADDR_W   = 7
);
  logic                       start_i;
  logic [ADDR_W-1:0]          base_i;
  logic [7:0]                 len_i;
  logic                       sram_cen_o;
  logic [SRAM_NUM-1:0]        sram_wen_o;
  logic [SRAM_NUM*ADDR_W-1:0] sram_a_o;
  logic [SRAM_NUM*16-1:0]     sram_q_i;
  logic                       out_valid_o;
  logic [SRAM_NUM*16-1:0]     out_data_o;
  logic                       out_last_o;
  logic                       out_ready_i;
  logic                       busy_o;
  logic                       done_o;

  // Reader side
  modport slave (
    input  start_i, base_i, len_i, sram_q_i, out_ready_i,
    output sram_cen_o, sram_wen_o, sram_a_o, out_valid_o, out_data_o,
           out_last_o, busy_o, done_o
  );

  // Controller / bank / consumer side
  modport master (
    output start_i, base_i, len_i, sram_q_i, out_ready_i,
    input  sram_cen_o, sram_wen_o, sram_a_o, out_valid_o, out_data_o,
           out_last_o, busy_o, done_o
  );
endinterface

// File: rtl/orsram_reader.sv
// Streams a contiguous block of words out of the orsram bank onto a
// valid/ready stream, hiding the one-cycle macro latency with a 2-entry skid FIFO.
module orsram_reader #(
  parameter int unsigned SRAM_NUM = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  orsram_reader_if.slave io_bus
);

  localparam int unsigned DATA_W = SRAM_NUM * 16;
  localparam int unsigned LEN_W  = 8;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(128);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_remain;
  logic                r_inflight;
  logic                r_inflight_last;
  logic                r_done;

  logic [DATA_W-1:0]   r_mem [2];
  logic [1:0]          r_mem_last;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic                w_issue_last;
  logic [1:0]          w_count_nxt;
  logic [LEN_W-1:0]    w_len_sat;

  // Handshake and occupancy bookkeeping
  assign w_valid      = (r_count != 2'd0);
  assign w_pop        = w_valid & io_bus.out_ready_i;
  assign w_push       = r_inflight;
  // Issue only if the word will have a FIFO slot when it lands next cycle.
  assign w_issue      = (r_state == ST_READ) &&
                        ((3'(r_count) + 3'(r_inflight)) < (3'd2 + 3'(w_pop)));
  assign w_issue_last = w_issue && (r_remain == LEN_W'(1));
  assign w_count_nxt  = r_count + 2'(w_push) - 2'(w_pop);
  assign w_len_sat    = (io_bus.len_i > LEN_MAX) ? LEN_MAX : io_bus.len_i;

  // Job FSM: address/length tracking, in-flight read tracking and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - LEN_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start_i) begin
            if (w_len_sat == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state  <= ST_READ;
              r_addr   <= io_bus.base_i;
              r_remain <= w_len_sat;
            end
          end
        end
        ST_READ: begin
          if (w_issue_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((w_count_nxt == 2'd0) && !r_inflight) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Skid FIFO: captures the bank output the cycle after each issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_mem_last <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]      <= io_bus.sram_q_i;
        r_mem_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
    end
  end

  assign io_bus.sram_cen_o  = ~w_issue;
  assign io_bus.sram_wen_o  = '1;
  assign io_bus.sram_a_o    = {SRAM_NUM{r_addr}};
  assign io_bus.out_valid_o = w_valid;
  assign io_bus.out_data_o  = r_mem[r_rd_ptr];
  assign io_bus.out_last_o  = r_mem_last[r_rd_ptr] & w_valid;
  assign io_bus.busy_o      = (r_state != ST_IDLE);
  assign io_bus.done_o      = r_done;

  // A landing read must always find a free slot
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((r_count == 2'd2) && w_push && !w_pop));

endmodule

// File: tb/tb_orsram_reader.sv
// Self-checking bench for orsram_reader with a behavioural SRAM bank and stream model.
module tb_orsram_reader;
  localparam int unsigned SRAM_NUM = 8;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = SRAM_NUM * 16;
  localparam int unsigned DEPTH    = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  orsram_reader_if #(.SRAM_NUM(SRAM_NUM), .ADDR_W(ADDR_W)) bus ();
  orsram_reader #(.SRAM_NUM(SRAM_NUM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bank: one-cycle read latency per macro
  logic [15:0] mem [SRAM_NUM][DEPTH];
  always @(posedge clk) begin
    logic [DATA_W-1:0] q;
    q = bus.sram_q_i;
    if (bus.sram_cen_o === 1'b0)
      for (int i = 0; i < SRAM_NUM; i++)
        q[i*16 +: 16] = mem[i][bus.sram_a_o[i*ADDR_W +: ADDR_W]];
    bus.sram_q_i <= q;
  end

  // Observation logs
  logic [DATA_W-1:0] got_data[$];
  logic              got_last[$];
  int                got_cyc[$];
  int                iss_addr[$];
  int                iss_cyc[$];
  int                done_cyc[$];
  logic              done_busy[$];
  int                busy_rise[$];
  int n_iss = 0, n_xfer = 0, pend_err = 0, stall_err = 0, repl_err = 0, wen_err = 0;
  logic              prev_stall = 1'b0, prev_busy = 1'b0, prev_last = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  // Mid-cycle monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sram_wen_o !== '1) wen_err++;
      if (n_iss - n_xfer > 2) pend_err++;
      if (prev_stall && (bus.out_valid_o !== 1'b1 || bus.out_data_o !== prev_data ||
                         bus.out_last_o !== prev_last)) stall_err++;
      prev_stall = bus.out_valid_o && !bus.out_ready_i;
      prev_data  = bus.out_data_o;
      prev_last  = bus.out_last_o;
      if (bus.sram_cen_o === 1'b0) begin
        iss_addr.push_back(int'(bus.sram_a_o[ADDR_W-1:0]));
        iss_cyc.push_back(cyc);
        for (int i = 1; i < SRAM_NUM; i++)
          if (bus.sram_a_o[i*ADDR_W +: ADDR_W] !== bus.sram_a_o[ADDR_W-1:0]) repl_err++;
        n_iss++;
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        got_data.push_back(bus.out_data_o);
        got_last.push_back(bus.out_last_o);
        got_cyc.push_back(cyc);
        n_xfer++;
      end
      if (bus.done_o) begin
        done_cyc.push_back(cyc);
        done_busy.push_back(bus.busy_o);
      end
      if (bus.busy_o && !prev_busy) busy_rise.push_back(cyc);
      prev_busy = bus.busy_o;
    end else begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  // Reference model: expected address/word/last sequence of a job
  logic [DATA_W-1:0] exp_data[$];
  logic              exp_last[$];
  int                exp_addr[$];

  function automatic logic [DATA_W-1:0] word_at(input int a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < SRAM_NUM; i++) w[i*16 +: 16] = mem[i][ADDR_W'(a)];
    return w;
  endfunction

  task automatic build_model(input int base, input int len);
    int n;
    n = (len > 128) ? 128 : len;
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
    for (int j = 0; j < n; j++) begin
      exp_addr.push_back((base + j) % DEPTH);
      exp_data.push_back(word_at((base + j) % DEPTH));
      exp_last.push_back(j == n - 1);
    end
  endtask

  task automatic preload_pattern();
    for (int i = 0; i < SRAM_NUM; i++)
      for (int k = 0; k < DEPTH; k++) mem[i][k] = 16'(k + i);
  endtask

  task automatic preload_random();
    for (int i = 0; i < SRAM_NUM; i++)
      for (int k = 0; k < DEPTH; k++) mem[i][k] = 16'($urandom);
  endtask

  task automatic clear_logs();
    got_data.delete(); got_last.delete(); got_cyc.delete();
    iss_addr.delete(); iss_cyc.delete(); done_cyc.delete();
    done_busy.delete(); busy_rise.delete();
    n_iss = 0; n_xfer = 0;
  endtask

  // Launch one job and run until done (bounded); optional re-pulse of start
  task automatic run_job(input int base, input int len, input bit rand_ready,
                         input int restart_at, output int c0);
    clear_logs();
    @(posedge clk); #1;
    bus.start_i     = 1'b1;
    bus.base_i      = ADDR_W'(base);
    bus.len_i       = 8'(len);
    bus.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    c0 = cyc;
    for (int k = 1; k < 1000 && done_cyc.size() == 0; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (k == restart_at) begin
        bus.start_i = 1'b1;
        bus.base_i  = ADDR_W'(0);
        bus.len_i   = 8'd3;
      end
      bus.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.start_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.sram_cen_o !== 1'b1) begin n_fail++; $display("FAIL reset_cen: got %0b expected 1", bus.sram_cen_o); end
    n_checks++; if (bus.sram_wen_o !== '1) begin n_fail++; $display("FAIL reset_wen: got %0h expected ff", bus.sram_wen_o); end
    n_checks++; if (bus.sram_a_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", bus.sram_a_o); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid_o); end
    n_checks++; if (bus.out_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b expected 0", bus.out_last_o); end
    n_checks++; if (bus.out_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", bus.out_data_o); end
    n_checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %0b/%0b expected 0/0", bus.busy_o, bus.done_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int c0;
    preload_pattern();
    build_model(5, 4);
    run_job(5, 4, 1'b0, 0, c0);
    n_checks++; if (got_data.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d words expected 4", got_data.size()); end
    for (int j = 0; j < exp_data.size() && j < got_data.size(); j++) begin
      n_checks++;
      if (got_data[j] !== exp_data[j] || got_last[j] !== exp_last[j] || got_cyc[j] != c0 + 3 + j) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %0h last %0b cyc %0d expected %0h last %0b cyc %0d", j,
                 got_data[j], got_last[j], got_cyc[j] - c0, exp_data[j], exp_last[j], 3 + j);
      end
    end
    n_checks++; if (iss_addr.size() != 4) begin n_fail++; $display("FAIL basic_issues: got %0d expected 4", iss_addr.size()); end
    for (int j = 0; j < exp_addr.size() && j < iss_addr.size(); j++) begin
      n_checks++; if (iss_addr[j] != exp_addr[j] || iss_cyc[j] != c0 + 1 + j) begin
        n_fail++; $display("FAIL basic_addr%0d: got %0d@%0d expected %0d@%0d", j, iss_addr[j], iss_cyc[j] - c0, exp_addr[j], 1 + j);
      end
    end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 7 || done_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at 7 with busy 0", done_cyc.size(),
                         (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1);
    end
    n_checks++; if (busy_rise.size() != 1 || busy_rise[0] != c0 + 1) begin
      n_fail++; $display("FAIL basic_busy_rise: got %0d rises expected 1 at cycle 1", busy_rise.size());
    end
  endtask

  task automatic test_wrap();
    int c0;
    build_model(126, 4);
    run_job(126, 4, 1'b0, 0, c0);
    n_checks++; if (iss_addr.size() != 4 || got_data.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d issues %0d words expected 4/4", iss_addr.size(), got_data.size()); end
    for (int j = 0; j < 4 && j < iss_addr.size() && j < got_data.size(); j++) begin
      n_checks++; if (iss_addr[j] != exp_addr[j] || got_data[j] !== exp_data[j]) begin
        n_fail++; $display("FAIL wrap_%0d: got addr %0d data %0h expected addr %0d data %0h", j, iss_addr[j], got_data[j], exp_addr[j], exp_data[j]);
      end
    end
  endtask

  task automatic test_len_zero();
    int c0;
    run_job(33, 0, 1'b0, 0, c0);
    n_checks++; if (iss_addr.size() != 0 || got_data.size() != 0) begin n_fail++; $display("FAIL zero_activity: got %0d issues %0d words expected 0/0", iss_addr.size(), got_data.size()); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 1 || busy_rise.size() != 0) begin
      n_fail++; $display("FAIL zero_done: got %0d pulses %0d busy rises expected done at cycle 1, no busy", done_cyc.size(), busy_rise.size());
    end
  endtask

  task automatic test_len_sat();
    int c0, base;
    base = $urandom_range(0, 127);
    build_model(base, 200);
    run_job(base, 200, 1'b0, 0, c0);
    n_checks++; if (got_data.size() != 128 || iss_addr.size() != 128) begin n_fail++; $display("FAIL sat_count: got %0d words %0d issues expected 128", got_data.size(), iss_addr.size()); end
    for (int j = 0; j < exp_data.size() && j < got_data.size(); j++) begin
      n_checks++; if (got_data[j] !== exp_data[j] || got_last[j] !== exp_last[j]) begin
        n_fail++; $display("FAIL sat_word%0d: got %0h last %0b expected %0h last %0b", j, got_data[j], got_last[j], exp_data[j], exp_last[j]);
      end
    end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 131) begin n_fail++; $display("FAIL sat_done: got %0d pulses expected 1 at cycle 131", done_cyc.size()); end
  endtask

  task automatic test_start_ignored();
    int c0;
    build_model(20, 6);
    run_job(20, 6, 1'b0, 3, c0);
    n_checks++; if (got_data.size() != 6 || iss_addr.size() != 6) begin n_fail++; $display("FAIL restart_count: got %0d words %0d issues expected 6", got_data.size(), iss_addr.size()); end
    for (int j = 0; j < exp_data.size() && j < got_data.size() && j < iss_addr.size(); j++) begin
      n_checks++; if (got_data[j] !== exp_data[j] || iss_addr[j] != exp_addr[j]) begin
        n_fail++; $display("FAIL restart_word%0d: got %0h addr %0d expected %0h addr %0d", j, got_data[j], iss_addr[j], exp_data[j], exp_addr[j]);
      end
    end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 9) begin n_fail++; $display("FAIL restart_done: got %0d pulses expected 1 at cycle 9", done_cyc.size()); end
  endtask

  task automatic test_backpressure();
    int c0, base;
    preload_random();
    for (int rep = 0; rep < 3; rep++) begin
      base = $urandom_range(0, 127);
      build_model(base, 16);
      run_job(base, 16, 1'b1, 0, c0);
      n_checks++; if (got_data.size() != 16 || iss_addr.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d words %0d issues expected 16", got_data.size(), iss_addr.size()); end
      for (int j = 0; j < exp_data.size() && j < got_data.size() && j < iss_addr.size(); j++) begin
        n_checks++; if (got_data[j] !== exp_data[j] || got_last[j] !== exp_last[j] || iss_addr[j] != exp_addr[j]) begin
          n_fail++; $display("FAIL bp_word%0d: got %0h last %0b addr %0d expected %0h last %0b addr %0d", j,
                             got_data[j], got_last[j], iss_addr[j], exp_data[j], exp_last[j], exp_addr[j]);
        end
      end
      n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", done_cyc.size()); end
    end
    n_checks++; if (pend_err != 0) begin n_fail++; $display("FAIL bp_occupancy: got %0d cycles over 2 outstanding expected 0", pend_err); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_err); end
    n_checks++; if (repl_err != 0 || wen_err != 0) begin n_fail++; $display("FAIL bus_static: got %0d addr/%0d wen errors expected 0", repl_err, wen_err); end
    preload_pattern();
  endtask

  task automatic test_async_reset();
    int c0;
    build_model(40, 10);
    clear_logs();
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.base_i = ADDR_W'(40); bus.len_i = 8'd10; bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int k = 0; k < 50 && got_data.size() < 3; k++) begin @(posedge clk); #1; end
    n_checks++; if (got_data.size() != 3 || got_data[2] !== exp_data[2]) begin n_fail++; $display("FAIL arst_pre: got %0d words expected 3 ending %0h", got_data.size(), exp_data[2]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.sram_cen_o !== 1'b1 || bus.sram_wen_o !== '1 || bus.sram_a_o !== '0) begin
      n_fail++; $display("FAIL arst_bank: got cen %0b wen %0h a %0h expected 1/ff/0", bus.sram_cen_o, bus.sram_wen_o, bus.sram_a_o);
    end
    n_checks++; if (bus.out_valid_o !== 1'b0 || bus.out_last_o !== 1'b0 || bus.out_data_o !== '0) begin
      n_fail++; $display("FAIL arst_stream: got valid %0b last %0b data %0h expected 0/0/0", bus.out_valid_o, bus.out_last_o, bus.out_data_o);
    end
    n_checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL arst_status: got busy %0b done %0b expected 0/0", bus.busy_o, bus.done_o); end
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done_cyc.size() != 0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_no_done: got %0d pulses busy %0b expected 0/0", done_cyc.size(), bus.busy_o); end
    build_model(10, 2);
    run_job(10, 2, 1'b0, 0, c0);
    n_checks++; if (got_data.size() != 2) begin n_fail++; $display("FAIL arst_after_count: got %0d expected 2", got_data.size()); end
    for (int j = 0; j < 2 && j < got_data.size(); j++) begin
      n_checks++; if (got_data[j] !== exp_data[j] || got_last[j] !== exp_last[j]) begin
        n_fail++; $display("FAIL arst_after_word%0d: got %0h last %0b expected %0h last %0b", j, got_data[j], got_last[j], exp_data[j], exp_last[j]);
      end
    end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 5) begin n_fail++; $display("FAIL arst_after_done: got %0d pulses expected 1 at cycle 5", done_cyc.size()); end
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.base_i      = '0;
    bus.len_i       = '0;
    bus.out_ready_i = 1'b1;
    preload_pattern();
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_len_sat();
    test_start_ignored();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
